// File: rtl/rca_seq_pkg.sv
// Shared constants for the nibble-serial word adder.
// Holds the slice width and the controller state encoding.
package rca_seq_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/rca_word_sequencer_if.sv
// Requester-side start/done bus of the word adder.
// Carries operands in and the held result out.
interface rca_word_sequencer_if #(
  parameter int unsigned NIBBLES = 4
);
  import rca_seq_pkg::*;

  localparam int unsigned W = NIBBLE_W * NIBBLES;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         c_out;
  logic         ovf;

  modport master (
    output start, a, b, c_in,
    input  busy, done, sum, c_out, ovf
  );

  modport slave (
    input  start, a, b, c_in,
    output busy, done, sum, c_out, ovf
  );

endinterface

// File: rtl/rca.sv
// Four-bit ripple-carry adder used as the shared slice datapath.
// Purely combinational; one full adder per bit.
module rca
  import rca_seq_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                c_in,
  output logic [NIBBLE_W-1:0] sum,
  output logic                c_out
);

  logic [NIBBLE_W:0] carry;

  assign carry[0] = c_in;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign c_out = carry[NIBBLE_W];

endmodule

// File: rtl/rca_word_sequencer.sv
// Word-width adder that walks one 4-bit rca across NIBBLES slices, LSB first,
// chaining the carry through a register between slices.
module rca_word_sequencer
  import rca_seq_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  rca_word_sequencer_if.slave   bus
);

  localparam int unsigned W     = NIBBLE_W * NIBBLES;
  localparam int unsigned IDX_W = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic [W-1:0]       sum_q, sum_d;
  logic               c_out_q, c_out_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  logic [NIBBLE_W-1:0] slice_a, slice_b, slice_sum;
  logic                slice_co;

  // Slice mux: current nibble of each latched operand
  assign slice_a = a_q[NIBBLE_W*int'(idx_q) +: NIBBLE_W];
  assign slice_b = b_q[NIBBLE_W*int'(idx_q) +: NIBBLE_W];

  rca u_rca (
    .a     (slice_a),
    .b     (slice_b),
    .c_in  (carry_q),
    .sum   (slice_sum),
    .c_out (slice_co)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.c_in;
          idx_d   = '0;
          sum_d   = '0;
          state_d = ST_ADD;
        end
      end
      ST_ADD: begin
        sum_d[NIBBLE_W*int'(idx_q) +: NIBBLE_W] = slice_sum;
        carry_d = slice_co;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == IDX_LAST) begin
          // Top slice: its sum MSB is the new word sign bit
          c_out_d = slice_co;
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (slice_sum[NIBBLE_W-1] != a_q[W-1]);
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.sum   = sum_q;
  assign bus.c_out = c_out_q;
  assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_rca_word_sequencer.sv
// Scoreboard bench for rca_word_sequencer: issued requests push expected
// results; a negedge monitor pops and compares on each done pulse.
module tb_rca_word_sequencer;
  import rca_seq_pkg::*;

  localparam int unsigned NIBBLES = 4;
  localparam int unsigned W       = NIBBLE_W * NIBBLES;

  typedef struct {
    logic [W-1:0] sum;
    logic         c_out;
    logic         ovf;
    int           acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rca_word_sequencer_if #(.NIBBLES(NIBBLES)) bus ();

  rca_word_sequencer #(.NIBBLES(NIBBLES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t sb[$];
  int   vectors = 0;
  int   errors  = 0;
  int   cyc     = 0;
  int   win_lo  = 0;
  int   win_hi  = -1;
  int   last_acc = 0;
  bit   b2b_chk = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [W-1:0] act,
                                input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endfunction

  // Reference: plain (W+1)-bit addition and the sign rule for overflow
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic ci, input int acc);
    exp_t e;
    logic [W:0] full;
    full    = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    e.sum   = full[W-1:0];
    e.c_out = full[W];
    e.ovf   = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
    e.acc   = acc;
    return e;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      check("busy", W'(bus.busy), W'((cyc >= win_lo && cyc <= win_hi) ? 1 : 0));
      if (bus.done === 1'b1) begin
        if (sb.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL unexpected_done at cycle %0d: got done=1 expected done=0", cyc);
        end else begin
          e = sb.pop_front();
          check("sum", bus.sum, e.sum);
          check("c_out", W'(bus.c_out), W'(e.c_out));
          check("ovf", W'(bus.ovf), W'(e.ovf));
          check("latency", W'(cyc - e.acc), W'(NIBBLES));
        end
      end
    end
  end

  // Present a request at the first idle negedge; acceptance is the next posedge
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ci, input bit hold);
    int t;
    int acc;
    t = 0;
    @(negedge clk);
    while (bus.busy !== 1'b0) begin
      bus.a    = W'($urandom);
      bus.b    = W'($urandom);
      bus.c_in = 1'($urandom);
      @(negedge clk);
      t++;
      if (t > 100) begin
        vectors++;
        errors++;
        $display("FAIL idle_timeout at cycle %0d: got busy=1 expected busy=0", cyc);
        return;
      end
    end
    bus.a     = a;
    bus.b     = b;
    bus.c_in  = ci;
    bus.start = 1'b1;
    acc = cyc + 1;
    sb.push_back(model(a, b, ci, acc));
    if (b2b_chk) check("spacing", W'(acc - last_acc), W'(NIBBLES + 2));
    last_acc = acc;
    win_lo   = acc;
    win_hi   = acc + NIBBLES;
    if (!hold) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
  endtask

  initial begin
    int t;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.c_in  = 1'b0;
    #1;
    check("rst_busy", W'(bus.busy), '0);
    check("rst_done", W'(bus.done), '0);
    check("rst_sum", bus.sum, '0);
    check("rst_c_out", W'(bus.c_out), '0);
    check("rst_ovf", W'(bus.ovf), '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    issue(16'h1234, 16'h4321, 1'b0, 1'b0);
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    issue(16'h0009, 16'h0006, 1'b1, 1'b0);
    issue(16'h7FFF, 16'h0001, 1'b0, 1'b0);

    // Start pulse with fresh operands during ADD must be ignored
    issue(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
    bus.c_in  = 1'($urandom);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;

    // Asynchronous reset after slice 2 is written
    issue(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    sb.delete();
    win_hi = -1;
    rst = 1'b1;
    #1;
    check("midrst_busy", W'(bus.busy), '0);
    check("midrst_sum", bus.sum, '0);
    check("midrst_c_out", W'(bus.c_out), '0);
    check("midrst_done", W'(bus.done), '0);
    @(negedge clk);
    rst = 1'b0;
    issue(16'h8000, 16'h8000, 1'b0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
    end
    issue(16'h8000, 16'hFFFF, 1'b0, 1'b0);
    issue(16'h7FFF, 16'h7FFF, 1'b1, 1'b0);

    // Back-to-back with start held high
    b2b_chk = 1'b0;
    issue(W'($urandom), W'($urandom), 1'($urandom), 1'b1);
    b2b_chk = 1'b1;
    for (int i = 0; i < 7; i++) issue(W'($urandom), W'($urandom), 1'($urandom), 1'b1);
    @(negedge clk);
    bus.start = 1'b0;
    b2b_chk = 1'b0;

    t = 0;
    while ((sb.size() != 0 || bus.busy !== 1'b0) && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0 || bus.busy !== 1'b0) begin
      vectors++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", sb.size());
    end
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
